// File: rtl/alu_issue.sv
// Issue controller for an external ALU32: accepts a command, holds the operands for SETTLE_CYCLES, then registers the result.
// Optional sticky overflow flag is enabled with macro ALU_ISSUE_STICKY_OVF_EN.
module alu_issue #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_cmd,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_op,
  input  logic [31:0] alu_s,
  input  logic        alu_zero,
  input  logic        alu_ovf,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_ovf,
  output logic        rsp_err,
  output logic        sticky_ovf,
  input  logic        sticky_clr
);

  // state | meaning
  // IDLE  | ready for a request, alu_op parked at 00000
  // ISSUE | operands held on the ALU, settle counter running
  // RESP  | response valid, waiting for rsp_ready
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_req_ready;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [4:0]  r_alu_op;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_result;
  logic        r_rsp_zero;
  logic        r_rsp_ovf;
  logic        r_rsp_err;

  logic        w_legal;
  logic [4:0]  w_op;
  logic        w_capture;
  logic        w_cap_ovf;

  always_comb begin
    w_legal = 1'b1;
    w_op    = 5'b00000;
    case (req_cmd)
      3'd0:    w_op = 5'b00000;
      3'd1:    w_op = 5'b00001;
      3'd2:    w_op = 5'b00010;
      3'd3:    w_op = 5'b01110;
      3'd4:    w_op = 5'b01111;
      3'd5:    w_op = 5'b11000;
      3'd6:    w_op = 5'b11001;
      default: w_legal = 1'b0;
    endcase
  end

  // Op1 is set only for the arithmetic ops (ADD/SUB/SLT), the only ones whose overflow is meaningful.
  assign w_capture = (r_state == ISSUE) && (r_cnt == 4'd1);
  assign w_cap_ovf = r_alu_op[1] & alu_ovf;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_req_ready  <= 1'b1;
      r_alu_a      <= 32'd0;
      r_alu_b      <= 32'd0;
      r_alu_op     <= 5'd0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= 32'd0;
      r_rsp_zero   <= 1'b0;
      r_rsp_ovf    <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_req_ready <= 1'b0;
            if (w_legal) begin
              r_alu_a  <= req_a;
              r_alu_b  <= req_b;
              r_alu_op <= w_op;
              r_cnt    <= 4'(SETTLE_CYCLES);
              r_state  <= ISSUE;
            end else begin
              r_rsp_result <= 32'd0;
              r_rsp_zero   <= 1'b0;
              r_rsp_ovf    <= 1'b0;
              r_rsp_err    <= 1'b1;
              r_rsp_valid  <= 1'b1;
              r_state      <= RESP;
            end
          end
        end
        ISSUE: begin
          r_cnt <= r_cnt - 4'd1;
          if (w_capture) begin
            r_rsp_result <= alu_s;
            r_rsp_zero   <= alu_zero;
            r_rsp_ovf    <= w_cap_ovf;
            r_rsp_err    <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_state      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_alu_op    <= 5'd0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ISSUE_STICKY_OVF_EN
  logic r_sticky_ovf;

  // A set in the same cycle as a clear wins so no overflow event is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_sticky_ovf <= 1'b0;
    else if (w_capture && w_cap_ovf)
      r_sticky_ovf <= 1'b1;
    else if (sticky_clr)
      r_sticky_ovf <= 1'b0;
  end

  assign sticky_ovf = r_sticky_ovf;
`else
  logic w_unused_clr;

  assign w_unused_clr = sticky_clr;
  assign sticky_ovf   = 1'b0;
`endif

  assign req_ready  = r_req_ready;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_op     = r_alu_op;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;
  assign rsp_ovf    = r_rsp_ovf;
  assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with SETTLE_CYCLES=4 and a behavioural ALU32 driving the alu_* inputs.
module tb_alu_issue;
  localparam int S = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_cmd = 3'd0;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic [31:0] alu_a, alu_b;
  logic [4:0]  alu_op;
  logic [31:0] alu_s;
  logic        alu_zero, alu_ovf;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_ovf, rsp_err;
  logic        sticky_ovf;
  logic        sticky_clr = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;
  int lat;
  logic [4:0]  op_seen;
  logic [31:0] a_seen;
  logic        seen_valid;
  logic        sticky_exp;

  alu_issue #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_s(alu_s), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
    .sticky_ovf(sticky_ovf), .sticky_clr(sticky_clr)
  );

  always #5 clk = ~clk;

  // ALU32: Ainvert, Binvert, CarryIn, Op1:Op0 (and/or/add/slt)
  logic [31:0] m_a, m_b, m_sum;
  logic        m_ovf;
  always_comb begin
    m_a   = alu_op[4] ? ~alu_a : alu_a;
    m_b   = alu_op[3] ? ~alu_b : alu_b;
    m_sum = m_a + m_b + {31'd0, alu_op[2]};
    m_ovf = (m_a[31] == m_b[31]) && (m_sum[31] != m_a[31]);
    case (alu_op[1:0])
      2'd0:    alu_s = m_a & m_b;
      2'd1:    alu_s = m_a | m_b;
      2'd2:    alu_s = m_sum;
      default: alu_s = {31'd0, m_sum[31] ^ m_ovf};
    endcase
    alu_zero = (alu_s == 32'd0);
    alu_ovf  = m_ovf;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic [31:0] res, input logic z, input logic o, input logic e);
    chk({tag, ".valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, ".result"}, rsp_result, res);
    chk({tag, ".zero"}, {31'd0, rsp_zero}, {31'd0, z});
    chk({tag, ".ovf"}, {31'd0, rsp_ovf}, {31'd0, o});
    chk({tag, ".err"}, {31'd0, rsp_err}, {31'd0, e});
  endtask

  // Presents one request, then waits (bounded) for rsp_valid; lat counts cycles from the accept cycle.
  task automatic issue(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       input logic clr, output int l, output logic [4:0] op_s, output logic [31:0] a_s);
    int t;
    t = 0;
    while (!req_ready && t < 50) begin @(posedge clk); #1; t++; end
    req_valid = 1'b1; req_cmd = cmd; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0; req_cmd = 3'd5; req_a = 32'hDEADBEEF; req_b = 32'hCAFEF00D;
    sticky_clr = clr;
    op_s = alu_op;
    a_s  = alu_a;
    l = 1;
    while (!rsp_valid && l < 50) begin @(posedge clk); #1; l++; end
    sticky_clr = 1'b0;
  endtask

  task automatic consume(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, ".valid_low"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, ".op_idle"}, {27'd0, alu_op}, 32'd0);
  endtask

  initial begin
`ifdef ALU_ISSUE_STICKY_OVF_EN
    sticky_exp = 1'b1;
`else
    sticky_exp = 1'b0;
`endif
    #3;
    chk("rst.valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst.op", {27'd0, alu_op}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    chk("rst.req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst.alu_a", alu_a, 32'd0);
    chk("rst.alu_b", alu_b, 32'd0);
    chk("rst.result", rsp_result, 32'd0);
    chk("rst.err", {31'd0, rsp_err}, 32'd0);
    chk("rst.sticky", {31'd0, sticky_ovf}, 32'd0);

    issue(3'd0, 32'd45, 32'd21, 1'b0, lat, op_seen, a_seen);
    chk("and.latency", lat, S + 1);
    chk("and.op", {27'd0, op_seen}, 32'd0);
    chk("and.alu_a", a_seen, 32'd45);
    chk("and.req_ready", {31'd0, req_ready}, 32'd0);
    chk_rsp("and", 32'd5, 1'b0, 1'b0, 1'b0);
    consume("and");
    chk("and.alu_a_hold", alu_a, 32'd45);

    issue(3'd3, 32'd45, 32'd45, 1'b0, lat, op_seen, a_seen);
    chk("sub.op", {27'd0, op_seen}, 32'b01110);
    chk("sub.latency", lat, S + 1);
    chk_rsp("sub", 32'd0, 1'b1, 1'b0, 1'b0);
    consume("sub");

    issue(3'd4, 32'd21, 32'd45, 1'b0, lat, op_seen, a_seen);
    chk("slt.op", {27'd0, op_seen}, 32'b01111);
    chk_rsp("slt", 32'd1, 1'b0, 1'b0, 1'b0);
    consume("slt");

    issue(3'd6, 32'hFFFF0000, 32'hFFFFFFFF, 1'b0, lat, op_seen, a_seen);
    chk("nand.op", {27'd0, op_seen}, 32'b11001);
    chk_rsp("nand", 32'h0000FFFF, 1'b0, 1'b0, 1'b0);
    consume("nand");

    issue(3'd2, 32'h7FFFFFFF, 32'd1, 1'b0, lat, op_seen, a_seen);
    chk("add.op", {27'd0, op_seen}, 32'b00010);
    chk_rsp("add", 32'h80000000, 1'b0, 1'b1, 1'b0);
    chk("add.sticky", {31'd0, sticky_ovf}, {31'd0, sticky_exp});
    consume("add");

    // sticky_clr held through the whole issue, including the overflowing capture edge
    issue(3'd2, 32'h7FFFFFFF, 32'd1, 1'b1, lat, op_seen, a_seen);
    chk_rsp("add2", 32'h80000000, 1'b0, 1'b1, 1'b0);
    chk("add2.sticky_setwins", {31'd0, sticky_ovf}, {31'd0, sticky_exp});
    sticky_clr = 1'b1;
    @(posedge clk); #1;
    sticky_clr = 1'b0;
    chk("add2.sticky_cleared", {31'd0, sticky_ovf}, 32'd0);
    consume("add2");

    issue(3'd7, 32'h1234, 32'h5678, 1'b0, lat, op_seen, a_seen);
    chk("ill.latency", lat, 1);
    chk("ill.op", {27'd0, op_seen}, 32'd0);
    chk("ill.alu_a", a_seen, 32'h7FFFFFFF);
    chk("ill.alu_b", alu_b, 32'd1);
    chk_rsp("ill", 32'd0, 1'b0, 1'b0, 1'b1);
    consume("ill");

    // OR whose adder path overflows: the reported ovf must still be 0
    issue(3'd1, 32'h70000000, 32'h10000000, 1'b0, lat, op_seen, a_seen);
    chk("or.op", {27'd0, op_seen}, 32'b00001);
    chk_rsp("or", 32'h70000000, 1'b0, 1'b0, 1'b0);
    chk("or.sticky", {31'd0, sticky_ovf}, 32'd0);
    consume("or");

    issue(3'd5, 32'd0, 32'd0, 1'b0, lat, op_seen, a_seen);
    chk("nor.op", {27'd0, op_seen}, 32'b11000);
    chk_rsp("nor", 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    req_valid = 1'b1; req_cmd = 3'd2; req_a = 32'd1; req_b = 32'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk_rsp("hold", 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
      chk("hold.req_ready", {31'd0, req_ready}, 32'd0);
      chk("hold.alu_a", alu_a, 32'd0);
    end
    req_valid = 1'b0;
    consume("hold");
    chk("hold.not_taken", alu_a, 32'd0);

    // Reset pulse in the middle of ISSUE
    req_valid = 1'b1; req_cmd = 3'd2; req_a = 32'd5; req_b = 32'd6;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mid.alu_a", alu_a, 32'd5);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("mid.valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid.alu_a_rst", alu_a, 32'd0);
    chk("mid.alu_b_rst", alu_b, 32'd0);
    chk("mid.op_rst", {27'd0, alu_op}, 32'd0);
    chk("mid.result_rst", rsp_result, 32'd0);
    chk("mid.err_rst", {31'd0, rsp_err}, 32'd0);
    chk("mid.sticky_rst", {31'd0, sticky_ovf}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen_valid = 1'b1;
    end
    chk("mid.no_rsp", {31'd0, seen_valid}, 32'd0);
    chk("mid.req_ready", {31'd0, req_ready}, 32'd1);

    issue(3'd3, 32'd10, 32'd3, 1'b0, lat, op_seen, a_seen);
    chk("post.latency", lat, S + 1);
    chk_rsp("post", 32'd7, 1'b0, 1'b0, 1'b0);
    consume("post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, legal range 1..15: number of cycles ALU operands/alu_op are held before the result is sampled.
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req_valid input 1, req_ready output 1: request handshake.
REQ-005 SHALL have ports req_cmd input 3, req_a input 32, req_b input 32: command and operands.
REQ-006 SHALL have ports alu_a output 32, alu_b output 32, alu_op output 5: drive to ALU32 (alu_op = Ainvert, Binvert, CarryIn, Op1, Op0).
REQ-007 SHALL have ports alu_s input 32, alu_zero input 1, alu_ovf input 1: ALU32 results.
REQ-008 SHALL have ports rsp_valid output 1, rsp_ready input 1: response handshake.
REQ-009 SHALL have ports rsp_result output 32, rsp_zero output 1, rsp_ovf output 1, rsp_err output 1: registered response.
REQ-010 SHALL have ports sticky_ovf output 1, sticky_clr input 1: overflow status (see Configuration).

Function
REQ-011 SHALL map req_cmd: 0 AND->00000, 1 OR->00001, 2 ADD->00010, 3 SUB->01110, 4 SLT->01111, 5 NOR->11000, 6 NAND->11001, 7 illegal.
REQ-012 SHALL implement FSM IDLE, ISSUE, RESP; req_ready = 1 only in IDLE.
REQ-013 SHALL, on req_valid&&req_ready with legal cmd at edge N, register req_a/req_b to alu_a/alu_b and the mapped alu_op, load counter with SETTLE_CYCLES, enter ISSUE.
REQ-014 SHALL decrement the counter each ISSUE cycle; at the edge it reaches zero (edge N+SETTLE_CYCLES) capture alu_s, alu_zero, alu_ovf into rsp_* and enter RESP.
REQ-015 SHALL force rsp_ovf = 0 for AND, OR, NOR, NAND; pass alu_ovf through for ADD, SUB, SLT.
REQ-016 SHALL, on illegal cmd at edge N, leave alu_a/alu_b/alu_op unchanged, enter RESP directly with rsp_err=1, rsp_result=0, rsp_zero=0, rsp_ovf=0.
REQ-017 SHALL clear rsp_err on every legal capture.
REQ-018 SHALL assert rsp_valid exactly in RESP and hold all rsp_* stable until rsp_valid&&rsp_ready, then return to IDLE on that edge.
REQ-019 SHALL NOT accept a new request in the cycle the response is consumed (req_ready rises the following cycle); min issue period SETTLE_CYCLES+2 cycles.
REQ-020 SHALL return alu_op to 00000 on entering IDLE; alu_a/alu_b hold last operands.
REQ-021 SHALL ignore req_cmd/req_a/req_b while req_ready=0.

Reset
REQ-022 SHALL, when reset_n=0, immediately force state IDLE, counter 0, alu_a/alu_b/alu_op 0, rsp_result 0, rsp_zero/rsp_ovf/rsp_err/rsp_valid 0, sticky_ovf 0; req_ready 1 after release.
REQ-023 SHALL abandon any in-flight operation on reset with no response produced.

Configuration
REQ-024 SHALL, with macro ALU_ISSUE_STICKY_OVF_EN defined, set sticky_ovf on any capture with rsp_ovf=1 and clear it when sticky_clr=1; simultaneous set and clear leaves it set.
REQ-025 SHALL, without ALU_ISSUE_STICKY_OVF_EN, tie sticky_ovf to 0 and ignore sticky_clr; ports remain present.

Verification
REQ-026 SHALL cover: cmd 0, A=45, B=21 -> alu_op 00000, rsp_result 5, rsp_ovf 0, rsp_valid exactly SETTLE_CYCLES+1 cycles after accept.
REQ-027 SHALL cover: cmd 3, A=45, B=45 -> rsp_result 0, rsp_zero 1; cmd 4, A=21, B=45 -> rsp_result 1.
REQ-028 SHALL cover: cmd 2, A=0x7FFFFFFF, B=1 -> rsp_result 0x80000000, rsp_ovf 1, sticky_ovf 1 (macro on) / 0 (macro off); sticky_clr with simultaneous overflow capture -> stays 1.
REQ-029 SHALL cover: cmd 7 -> rsp_err 1, rsp_result 0, alu_op unchanged; next legal cmd -> rsp_err 0.
REQ-030 SHALL cover: rsp_ready held 0 for 5 cycles in RESP -> rsp_* stable, req_ready 0, new req_valid ignored.
REQ-031 SHALL cover: reset_n pulsed low during ISSUE with SETTLE_CYCLES=4 -> all outputs to reset values, no rsp_valid, next request serviced normally.
